// File: rtl/shift_sequencer.sv
// Multi-cycle controller that sequences an external 8-bit shifter (shift by 1/2, rotate by 1)
// to perform arbitrary-amount shifts and rotates behind a command/result handshake.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_kind,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic [WIDTH-1:0] sh_d_in,
    output logic [2:0]       sh_op,
    output logic             sh_capture,
    input  logic [WIDTH-1:0] sh_d_out
);

    localparam logic [1:0] KIND_SLL = 2'b00;
    localparam logic [1:0] KIND_SRL = 2'b01;
    localparam logic [1:0] KIND_ROL = 2'b10;

    localparam logic [2:0] OP_SLL1 = 3'b000;
    localparam logic [2:0] OP_SRL1 = 3'b001;
    localparam logic [2:0] OP_SLL2 = 3'b010;
    localparam logic [2:0] OP_SRL2 = 3'b011;
    localparam logic [2:0] OP_ROL1 = 3'b100;
    localparam logic [2:0] OP_ROR1 = 3'b101;
    localparam logic [2:0] OP_HOLD = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data_r;
    logic [1:0]       kind_r;
    logic [AMT_W-1:0] rem_r;
    logic             first_r;

    logic             accept;
    logic [AMT_W-1:0] step;
    logic [2:0]       run_op;
    logic [WIDTH-1:0] operand;

    assign accept = cmd_valid && (state == IDLE);

    // The first step loads the latched operand; later steps chain the shifter's own output.
    assign operand = first_r ? data_r : sh_d_out;

    always_comb begin
        step   = AMT_W'(1);
        run_op = OP_ROR1;
        case (kind_r)
            KIND_SLL: begin
                if (rem_r >= AMT_W'(2)) begin
                    run_op = OP_SLL2;
                    step   = AMT_W'(2);
                end else begin
                    run_op = OP_SLL1;
                end
            end
            KIND_SRL: begin
                if (rem_r >= AMT_W'(2)) begin
                    run_op = OP_SRL2;
                    step   = AMT_W'(2);
                end else begin
                    run_op = OP_SRL1;
                end
            end
            KIND_ROL: run_op = OP_ROL1;
            default:  run_op = OP_ROR1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            data_r  <= '0;
            kind_r  <= '0;
            rem_r   <= '0;
            first_r <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        kind_r  <= cmd_kind;
                        rem_r   <= cmd_amt;
                        data_r  <= cmd_data;
                        first_r <= 1'b1;
                    end
                end
                RUN: begin
                    rem_r   <= rem_r - step;
                    first_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (cmd_amt != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (rem_r == step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE);
        res_valid  = (state == DONE);
        busy       = (state != IDLE);
        sh_capture = 1'b1;
        sh_op      = OP_HOLD;
        sh_d_in    = operand;
        res_data   = operand;
        if (state == RUN) begin
            sh_capture = 1'b0;
            sh_op      = run_op;
        end
    end

endmodule
